// File: rtl/radio_transceiver.sv
`timescale 1ns/1ps
// Half-duplex UART-style radio front-end: serializes controller bytes onto tx_out
// and deserializes rx_in frames onto the shared radio_data bus.
module radio_transceiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       radio_enable,
  input  logic       radio_send,
  input  logic       radio_receive,
  output logic       radio_busy,
  inout  wire  [7:0] radio_data,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       tx_done,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]       r_tx_bit, w_tx_bit_nxt;
  logic [7:0]       r_tx_shift, w_tx_shift_nxt;
  logic             r_tx_out, w_tx_out_nxt;
  logic             r_tx_done, w_tx_done_nxt;
  logic             r_tx_armed, w_tx_armed_nxt;

  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic [7:0]       r_rx_byte;
  logic             r_rx_valid, w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             w_rx_load;
  logic             r_rx_sync_p0, r_rx_sync_p1, r_rx_sync_p2;

  logic w_tx_active, w_hunt, w_fall;

  assign w_tx_active = (r_tx_state != TX_IDLE);
  assign w_hunt      = radio_enable & radio_receive & ~radio_send & ~w_tx_active & ~r_rx_valid;
  assign w_fall      = r_rx_sync_p2 & ~r_rx_sync_p1;

  assign radio_busy = w_tx_active | (radio_enable & radio_receive & ~radio_send & ~r_rx_valid);
  assign radio_data = (radio_receive && !radio_send && r_rx_valid) ? r_rx_byte : 8'bz;
  assign tx_out     = r_tx_out;
  assign tx_done    = r_tx_done;
  assign frame_err  = r_frame_err;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_out_nxt   = r_tx_out;
    w_tx_done_nxt  = 1'b0;
    w_tx_armed_nxt = r_tx_armed;
    if (!radio_send) w_tx_armed_nxt = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_out_nxt = 1'b1;
        if (radio_enable && radio_send && r_tx_armed) begin
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = radio_data;
          w_tx_out_nxt   = 1'b0;
          w_tx_armed_nxt = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = 3'd0;
          w_tx_state_nxt = TX_DATA;
          w_tx_out_nxt   = r_tx_shift[0];
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == 3'd7) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_out_nxt   = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 3'd1;
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_out_nxt   = r_tx_shift[1];
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        // Registered pulse lands in the final stop-bit cycle
        w_tx_done_nxt = (r_tx_cnt == BIT_PRE);
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_IDLE;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_ONE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_cnt_nxt    = r_rx_cnt;
    w_rx_bit_nxt    = r_rx_bit;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_valid_nxt  = r_rx_valid;
    w_frame_err_nxt = 1'b0;
    w_rx_load       = 1'b0;
    if (!radio_receive) w_rx_valid_nxt = 1'b0;
    if (r_rx_state != RX_IDLE && !w_hunt) begin
      w_rx_state_nxt = RX_IDLE;
      w_rx_cnt_nxt   = '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (w_hunt && w_fall) begin
            w_rx_state_nxt = RX_START;
            w_rx_cnt_nxt   = '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == BIT_MID) begin
            w_rx_cnt_nxt   = '0;
            w_rx_bit_nxt   = 3'd0;
            w_rx_state_nxt = r_rx_sync_p1 ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rx_sync_p1, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            else                  w_rx_bit_nxt   = r_rx_bit + 3'd1;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == BIT_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_state_nxt = RX_IDLE;
            if (r_rx_sync_p1) begin
              w_rx_load      = 1'b1;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_frame_err_nxt = 1'b1;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
          end
        end
        default: w_rx_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit     <= 3'd0;
      r_tx_out     <= 1'b1;
      r_tx_done    <= 1'b0;
      r_tx_armed   <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= 3'd0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_rx_sync_p0 <= 1'b1;
      r_rx_sync_p1 <= 1'b1;
      r_rx_sync_p2 <= 1'b1;
    end else begin
      r_tx_state   <= w_tx_state_nxt;
      r_tx_cnt     <= w_tx_cnt_nxt;
      r_tx_bit     <= w_tx_bit_nxt;
      r_tx_out     <= w_tx_out_nxt;
      r_tx_done    <= w_tx_done_nxt;
      r_tx_armed   <= w_tx_armed_nxt;
      r_rx_state   <= w_rx_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_rx_bit     <= w_rx_bit_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_rx_sync_p0 <= rx_in;
      r_rx_sync_p1 <= r_rx_sync_p0;
      r_rx_sync_p2 <= r_rx_sync_p1;
    end
  end

  // Shift and holding registers carry data only; control state gates their use
  always_ff @(posedge clk) begin
    r_tx_shift <= w_tx_shift_nxt;
    r_rx_shift <= w_rx_shift_nxt;
    if (w_rx_load) r_rx_byte <= r_rx_shift;
  end

endmodule

// File: tb/tb_radio_transceiver.sv
`timescale 1ns/1ps
// Directed bench for radio_transceiver at 4 clocks per bit; undriven bus reads as 8'hFF.
module tb_radio_transceiver;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, send, recv, rx_in;
  logic [7:0] drv_data;
  wire  [7:0] radio_data;
  logic       busy, tx_out, tx_done, frame_err;
  int         n_checks = 0;
  int         n_errors = 0;

  assign radio_data = send ? drv_data : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (radio_data[g]);
  end

  always #5 clk = ~clk;

  radio_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .radio_enable(en), .radio_send(send),
    .radio_receive(recv), .radio_busy(busy), .radio_data(radio_data),
    .rx_in(rx_in), .tx_out(tx_out), .tx_done(tx_done), .frame_err(frame_err)
  );

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = fr[i];
      repeat (CPB) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  task automatic run_tx_frame(input logic [7:0] b);
    logic [9:0] fr;
    logic       exp_done;
    fr = {1'b1, b, 1'b0};
    en = 1'b1; drv_data = b; send = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_done = (k == 40);
      n_checks++;
      if (tx_out !== fr[(k-1)/CPB]) begin
        n_errors++; $display("FAIL tx_out[%0d] byte %h: got %b want %b", k, b, tx_out, fr[(k-1)/CPB]);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_errors++; $display("FAIL tx_busy[%0d]: got %b want 1", k, busy);
      end
      n_checks++;
      if (tx_done !== exp_done) begin
        n_errors++; $display("FAIL tx_done[%0d]: got %b want %b", k, tx_done, exp_done);
      end
    end
    for (int k = 41; k <= 48; k++) begin
      @(negedge clk);
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
        n_errors++; $display("FAIL tx_after[%0d]: got out=%b busy=%b done=%b want 1 0 0", k, tx_out, busy, tx_done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; send = 1'b0; recv = 1'b0; rx_in = 1'b1; drv_data = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (tx_out !== 1'b1) begin n_errors++; $display("FAIL reset_tx_out: got %b want 1", tx_out); end
    n_checks++; if (tx_done !== 1'b0) begin n_errors++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL reset_bus: got %h want ff", radio_data); end
    en = 1'b1; recv = 1'b1; #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL reset_rx_busy: got %b want 1", busy); end
    recv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx();
    en = 1'b0; send = 1'b1; drv_data = 8'hA5;
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        n_errors++; $display("FAIL tx_disabled: got out=%b busy=%b want 1 0", tx_out, busy);
      end
    end
    send = 1'b0;
    @(negedge clk);
    run_tx_frame(8'hA5);
    send = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rx();
    en = 1'b1; send = 1'b0; recv = 1'b1; #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rx_busy_start: got %b want 1", busy); end
    rx_frame(8'h3C, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rx_busy_pre_stop: got %b want 1", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL rx_bus_pre_stop: got %h want ff", radio_data); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rx_busy_done: got %b want 0", busy); end
    n_checks++; if (radio_data !== 8'h3C) begin n_errors++; $display("FAIL rx_data: got %h want 3c", radio_data); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL rx_frame_err: got %b want 0", frame_err); end
    repeat (3) @(negedge clk);
    n_checks++; if (radio_data !== 8'h3C) begin n_errors++; $display("FAIL rx_data_hold: got %h want 3c", radio_data); end
    recv = 1'b0; #1;
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL rx_bus_release: got %h want ff", radio_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rx_busy_release: got %b want 0", busy); end
    @(negedge clk);
    recv = 1'b1; #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rx_valid_cleared: busy got %b want 1", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL rx_bus_cleared: got %h want ff", radio_data); end
    recv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_bad_stop();
    en = 1'b1; send = 1'b0; recv = 1'b1;
    rx_frame(8'h55, 1'b0);
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL bad_stop_early_err: got %b want 0", frame_err); end
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b1) begin n_errors++; $display("FAIL bad_stop_err: got %b want 1", frame_err); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL bad_stop_busy: got %b want 1", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL bad_stop_bus: got %h want ff", radio_data); end
    @(negedge clk);
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL bad_stop_pulse_len: got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL bad_stop_busy2: got %b want 1", busy); end
    rx_frame(8'h12, 1'b1);
    @(negedge clk);
    n_checks++; if (radio_data !== 8'h12) begin n_errors++; $display("FAIL after_bad_data: got %h want 12", radio_data); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL after_bad_busy: got %b want 0", busy); end
    recv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_glitch();
    int n_err_pulses;
    n_err_pulses = 0;
    en = 1'b1; send = 1'b0; recv = 1'b1;
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (frame_err === 1'b1) n_err_pulses++;
    end
    n_checks++; if (n_err_pulses != 0) begin n_errors++; $display("FAIL glitch_err: got %0d pulses want 0", n_err_pulses); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy: got %b want 1", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL glitch_bus: got %h want ff", radio_data); end
    rx_frame(8'hC6, 1'b1);
    @(negedge clk);
    n_checks++; if (radio_data !== 8'hC6) begin n_errors++; $display("FAIL glitch_next_data: got %h want c6", radio_data); end
    recv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    en = 1'b1; recv = 1'b1;
    fork
      run_tx_frame(8'h69);
      rx_frame(8'h3C, 1'b1);
    join
    send = 1'b0; #1;
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL contention_rx_valid: busy got %b want 1", busy); end
    n_checks++; if (radio_data !== 8'hFF) begin n_errors++; $display("FAIL contention_bus: got %h want ff", radio_data); end
    recv = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    send = 1'b0; recv = 1'b0;
    @(negedge clk);
    en = 1'b1; drv_data = 8'hF0; send = 1'b1;
    repeat (14) @(negedge clk);
    n_checks++; if (tx_out !== 1'b0) begin n_errors++; $display("FAIL midrst_pre_out: got %b want 0", tx_out); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_out !== 1'b1) begin n_errors++; $display("FAIL midrst_out: got %b want 1", tx_out); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    rst_n = 1'b1; send = 1'b0;
    @(negedge clk);
    run_tx_frame(8'hC3);
    send = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_bad_stop();
    test_glitch();
    test_contention();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/radio_transceiver.md
Name: radio_transceiver

Overview:
- Half-duplex serial radio front-end; sits directly downstream of the node controller's radio port (radio_enable / radio_send / radio_receive / radio_busy / radio_data).
- Serializes a controller byte onto the air-side line tx_out as a UART-style frame: start bit, 8 data bits LSB-first, stop bit.
- Deserializes frames arriving on rx_in and presents the received byte on the shared radio_data bus.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=4); counter width $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- radio_enable  input  1  module enable from controller; gates all new TX/RX activity.
- radio_send  input  1  request transmit of radio_data.
- radio_receive  input  1  request receive of one byte.
- radio_busy  output  1  high while TX frame active or RX request pending without a valid byte.
- radio_data  inout  8  bus; sampled on TX accept; driven with rx_byte when radio_receive && !radio_send && rx_valid, else 8'bz.
- rx_in  input  1  serial receive line, idle high, asynchronous.
- tx_out  output  1  serial transmit line, idle high.
- tx_done  output  1  one-cycle pulse on the cycle the stop bit completes.
- frame_err  output  1  one-cycle pulse when a received stop bit samples 0.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low.
- Reset values (rst_n low at an edge): tx_out=1; tx_done=0; frame_err=0; rx_valid=0; tx_armed=1; TX FSM=TX_IDLE; RX FSM=RX_IDLE; all counters=0.
  - Reset mid-frame aborts immediately: tx_out is 1 after that edge.
  - A partial RX byte is discarded.
- radio_busy is combinational: tx_active | (radio_enable & radio_receive & !radio_send & !rx_valid).
- TX accept:
  - Condition at a rising edge: radio_enable & radio_send & tx_armed & TX_IDLE.
  - On accept: latch radio_data into the shift register, clear tx_armed, go to TX_START, tx_out<=0 on that same edge.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - TX_DATA shifts LSB-first over 8 bits; TX_STOP drives 1.
  - Full frame is 10*CLKS_PER_BIT cycles from the accept edge.
  - tx_done pulses in the last stop-bit cycle; the FSM is in TX_IDLE on the following edge.
- TX re-arm: tx_armed sets on any edge where radio_send==0. Holding radio_send high never emits a second frame.
- Deasserting radio_enable or radio_send mid-frame does not abort TX; only reset does.
- rx_in synchronizer: 2-flop, reset value 1. All RX logic uses the synchronized signal.
- RX hunting condition: radio_enable & radio_receive & !radio_send & !tx_active & !rx_valid.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
  - RX_IDLE: a falling edge (sync 1->0) while hunting -> RX_START.
  - RX_START: sample at CLKS_PER_BIT/2. If the line is back to 1 (glitch), return to RX_IDLE with no error.
  - RX_DATA: 8 samples, each CLKS_PER_BIT after the previous, LSB-first.
  - RX_STOP: sample once more.
    - Stop=1: rx_byte latched, rx_valid<=1.
    - Stop=0: frame_err pulse, byte discarded, back to RX_IDLE still hunting.
- RX abort: if hunting conditions drop mid-frame (enable/receive low or send high), RX returns to RX_IDLE with no error.
- rx_valid clears on the first edge where radio_receive==0 (byte consumed). A new byte cannot overwrite an unread one.
- Simultaneous send & receive: send wins. radio_data is not driven by this block and RX is suspended.
- radio_data is never driven while radio_send is high (no bus contention with the controller).

Test Plan:
- CLKS_PER_BIT=4, reset, radio_enable=1, radio_send=1, radio_data=8'hA5:
  - tx_out = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - radio_busy high exactly 40 cycles; tx_done one pulse at cycle 40.
  - No second frame while send stays high.
- Receive: radio_receive=1, drive rx_in frame for 8'h3C at 4 clk/bit:
  - radio_busy high until the stop sample; then radio_data=8'h3C and busy=0.
  - Drop receive: radio_data goes to z and rx_valid clears.
- Bad stop bit: frame 8'h55 with stop=0 -> frame_err one-cycle pulse, radio_busy stays high, radio_data stays z; a following good 8'h12 frame is received correctly.
- Glitch: rx_in low for 1 cycle then high -> no byte, no frame_err, FSM back to RX_IDLE.
- Mid-frame reset: rst_n low at cycle 15 of a TX frame -> tx_out=1 next edge, busy=0; a new send after reset produces a full, correct frame.
- Contention: radio_send=1 and radio_receive=1 together with rx_in active -> TX frame emitted, radio_data never driven by this block, no rx_valid set.
